updown_mod_counter: RTL and testbench

- Parametrised successor to the team's fixed 4-bit down counter.
- Configurable width and modulus, run-time direction control, synchronous parallel load and count enable.
- Wrap or saturate at the range limits, with terminal-count and event flags.
- Used as a general timebase/event counter in the sequential-circuits lab set (e.g. BCD digit, clock divider, timeout).

---
 rtl/updown_mod_counter.sv | 75 +++++++
 tb/tb_updown_mod_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with synchronous load and count enable.
// Wraps (with a one-cycle wrap_p pulse) or saturates (with sat flag) at the range limits.
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_out,
    output logic             tc,
    output logic             wrap_p,
    output logic             sat
);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("updown_mod_counter: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_d, q_q;
    logic             wrap_d, wrap_q;
    logic             sat_d, sat_q;
    logic             at_top, at_bot, limit_hit;

    assign at_top    = (q_q == MaxVal);
    assign at_bot    = (q_q == '0);
    // Limit is checked before stepping so the increment never overflows past MaxVal.
    assign limit_hit = up_dn ? at_top : at_bot;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        sat_d  = sat_q;
        if (load) begin
            q_d   = ({1'b0, load_val} > {1'b0, MaxVal}) ? MaxVal : load_val;
            sat_d = 1'b0;
        end else if (en) begin
            sat_d = 1'b0;
            if (limit_hit) begin
                if (SATURATE) begin
                    sat_d = 1'b1;
                end else begin
                    q_d    = up_dn ? '0 : MaxVal;
                    wrap_d = 1'b1;
                end
            end else begin
                q_d = up_dn ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

    assign q_out  = q_q;
    assign wrap_p = wrap_q;
    assign sat    = sat_q;
    assign tc     = limit_hit;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed, table-driven bench for updown_mod_counter: wrap (M=10), saturate (M=10) and M=2
// instances share one stimulus bus; each table row names the instance it checks.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] q_w, q_s, q_2;
    logic       tc_w, tc_s, tc_2;
    logic       wr_w, wr_s, wr_2;
    logic       st_w, st_s, st_2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .q_out(q_w), .tc(tc_w), .wrap_p(wr_w), .sat(st_w)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .q_out(q_s), .tc(tc_s), .wrap_p(wr_s), .sat(st_s)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(2), .SATURATE(1'b0)) dut_2 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .q_out(q_2), .tc(tc_2), .wrap_p(wr_2), .sat(st_2)
    );

    typedef struct {
        int         dut;
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       ud;
        logic [3:0] q;
        logic       tc;
        logic       wr;
        logic       st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int d, input logic l, input logic [3:0] v, input logic e,
                       input logic u, input logic [3:0] q, input logic t, input logic w,
                       input logic s);
        vec_t r;
        r.dut = d; r.ld = l; r.lv = v; r.en = e; r.ud = u;
        r.q = q; r.tc = t; r.wr = w; r.st = s;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic l, input logic [3:0] v, input logic e, input logic u);
        @(negedge clk);
        load = l; load_val = v; en = e; up_dn = u;
        @(posedge clk);
        #1;
    endtask

    task automatic check_dut(input string tag, input int d, input logic [3:0] q,
                             input logic t, input logic w, input logic s);
        logic [3:0] aq;
        logic       at, aw, as;
        case (d)
            0:       begin aq = q_w; at = tc_w; aw = wr_w; as = st_w; end
            1:       begin aq = q_s; at = tc_s; aw = wr_s; as = st_s; end
            default: begin aq = q_2; at = tc_2; aw = wr_2; as = st_2; end
        endcase
        check({tag, " q_out"}, 32'(aq), 32'(q));
        check({tag, " tc"}, 32'(at), 32'(t));
        check({tag, " wrap_p"}, 32'(aw), 32'(w));
        check({tag, " sat"}, 32'(as), 32'(s));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Wrap, M=10: count up 12 edges from reset.
        for (int i = 1; i <= 12; i++) begin
            logic [3:0] qv;
            qv = 4'(i % 10);
            add(0, 0, 0, 1, 1, qv, qv == 4'd9, i == 10, 0);
        end
        // Load 3 then count down through the wrap.
        add(0, 1, 3, 0, 0, 3, 0, 0, 0);
        add(0, 0, 0, 1, 0, 2, 0, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 9, 0, 1, 0);
        add(0, 0, 0, 1, 0, 8, 0, 0, 0);
        // Clamped load, then hold.
        add(0, 1, 14, 0, 1, 9, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 9, 1, 0, 0);
        // Saturate, M=10.
        add(1, 1, 7, 0, 1, 7, 0, 0, 0);
        add(1, 0, 0, 1, 1, 8, 0, 0, 0);
        add(1, 0, 0, 1, 1, 9, 1, 0, 0);
        add(1, 0, 0, 1, 1, 9, 1, 0, 1);
        add(1, 0, 0, 1, 1, 9, 1, 0, 1);
        add(1, 0, 0, 1, 1, 9, 1, 0, 1);
        add(1, 0, 0, 0, 1, 9, 1, 0, 1);
        add(1, 0, 0, 1, 0, 8, 0, 0, 0);
        add(1, 0, 0, 1, 1, 9, 1, 0, 0);
        add(1, 0, 0, 1, 1, 9, 1, 0, 1);
        add(1, 1, 9, 1, 1, 9, 1, 0, 0);
        // M=2: continuous up, then alternating direction for back-to-back wraps.
        add(2, 1, 0, 0, 1, 0, 0, 0, 0);
        add(2, 0, 0, 1, 1, 1, 1, 0, 0);
        add(2, 0, 0, 1, 1, 0, 0, 1, 0);
        add(2, 0, 0, 1, 1, 1, 1, 0, 0);
        add(2, 0, 0, 1, 1, 0, 0, 1, 0);
        add(2, 0, 0, 1, 0, 1, 0, 1, 0);
        add(2, 0, 0, 1, 1, 0, 0, 1, 0);
        add(2, 0, 0, 1, 0, 1, 0, 1, 0);
        add(2, 1, 14, 0, 1, 1, 1, 0, 0);

        // Reset state while reset is held.
        @(posedge clk);
        #1;
        check_dut("reset w", 0, 0, 0, 0, 0);
        check_dut("reset s", 1, 0, 0, 0, 0);
        check_dut("reset m2", 2, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ud);
            check_dut($sformatf("vec%0d", i), vecs[i].dut, vecs[i].q, vecs[i].tc,
                      vecs[i].wr, vecs[i].st);
        end

        // Async reset between edges clears a live wrap pulse and a live sat flag.
        step(1, 8, 0, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        check_dut("pre-rst w", 0, 0, 0, 1, 0);
        check_dut("pre-rst s", 1, 9, 1, 0, 1);
        #2 reset = 1'b1;
        #1;
        check_dut("async w", 0, 0, 0, 0, 0);
        check_dut("async s", 1, 0, 0, 0, 0);

        // Release with a load on the first edge, then reset mid-count at q_out=6.
        @(negedge clk);
        reset = 1'b0; load = 1'b1; load_val = 4'd5; en = 1'b0;
        @(posedge clk);
        #1;
        check("release load q_out", 32'(q_w), 32'd5);
        step(0, 0, 1, 1);
        check("count to 6", 32'(q_w), 32'd6);
        #2 reset = 1'b1;
        #1;
        check("mid-count reset q_out", 32'(q_w), 32'd0);
        check("mid-count reset wrap_p", 32'(wr_w), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("held reset q_out %0d", i), 32'(q_w), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first edge after release", 32'(q_w), 32'd1);
        step(0, 0, 1, 1);
        check("second edge after release", 32'(q_w), 32'd2);
        step(1, 5, 1, 1);
        check("load beats en q_out", 32'(q_w), 32'd5);
        step(0, 0, 1, 1);
        check("count after load", 32'(q_w), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
